cva6_multiport_fifo: RTL

Multi-port FIFO for the superscalar paths in CVA6, such as dual-issue decode/issue buffering and multi-entry commit queues. In one cycle it accepts 0..NR_PORTS in-order pushes and delivers 0..NR_PORTS in-order pops. Storage is a flop array with arbitrary (non-power-of-two) depth, an optional fall-through mode and a programmable almost-full threshold. It generalises the single-port `fifo_v3`-style queue to several lanes per cycle.

---
 rtl/cva6_multiport_fifo.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/cva6_multiport_fifo.sv
// Multi-lane in-order FIFO: 0..NR_PORTS pushes and pops per cycle.
// Optional CVA6_MPFIFO_CHECK_EN clamps illegal counts and raises err_o.
module cva6_multiport_fifo #(
    parameter int   DATA_WIDTH   = 32,
    parameter int   DEPTH        = 8,
    parameter int   NR_PORTS     = 2,
    parameter bit   FALL_THROUGH = 1'b0,
    parameter int   AFULL_THRESH = DEPTH - NR_PORTS,
    parameter type  dtype        = logic [DATA_WIDTH-1:0],
    parameter int   CNT_W        = $clog2(DEPTH + 1),
    parameter int   PCNT_W       = $clog2(NR_PORTS + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic [PCNT_W-1:0] push_cnt_i,
    input  dtype              data_i [NR_PORTS],
    input  logic [PCNT_W-1:0] pop_cnt_i,
    output dtype              data_o [NR_PORTS],
    output logic [PCNT_W-1:0] avail_o,
    output logic [CNT_W-1:0]  free_o,
    output logic [CNT_W-1:0]  usage_o,
    output logic              full_o,
    output logic              almost_full_o,
    output logic              empty_o,
    output logic              err_o
);

    localparam int SW = CNT_W + 1;

    logic [CNT_W-1:0]  rd_q, rd_d, wr_q, wr_d, cnt_q, cnt_d;
    dtype              mem_q [DEPTH];
    logic [PCNT_W-1:0] push_eff, pop_eff, avail;
    logic [CNT_W-1:0]  free;
    logic [SW-1:0]     ready_sum;
    logic              we   [NR_PORTS];
    logic [CNT_W-1:0]  widx [NR_PORTS];
    logic [CNT_W-1:0]  ridx [NR_PORTS];
    logic              clamp;

    // Index add modulo DEPTH without relying on power-of-two truncation
    function automatic logic [CNT_W-1:0] wrap_add(
        input logic [CNT_W-1:0] a,
        input logic [SW-1:0]    b
    );
        logic [SW-1:0] s;
        s = {1'b0, a} + b;
        if (s >= SW'(DEPTH)) s = s - SW'(DEPTH);
        return s[CNT_W-1:0];
    endfunction

    assign free = CNT_W'(DEPTH) - cnt_q;

    // Effective push/pop counts and poppable entry count
    always_comb begin
        push_eff = push_cnt_i;
        pop_eff  = pop_cnt_i;
        clamp    = 1'b0;
`ifdef CVA6_MPFIFO_CHECK_EN
        if (CNT_W'(push_cnt_i) > free) begin
            push_eff = free[PCNT_W-1:0];
            clamp    = 1'b1;
        end
`endif
        ready_sum = SW'(cnt_q);
        if (FALL_THROUGH) ready_sum = ready_sum + SW'(push_eff);
        if (ready_sum > SW'(NR_PORTS)) avail = PCNT_W'(NR_PORTS);
        else avail = ready_sum[PCNT_W-1:0];
`ifdef CVA6_MPFIFO_CHECK_EN
        if (pop_cnt_i > avail) begin
            pop_eff = avail;
            clamp   = 1'b1;
        end
`endif
    end

    // Next pointers and count; flush wins over push and pop
    always_comb begin
        rd_d  = wrap_add(rd_q, SW'(pop_eff));
        wr_d  = wrap_add(wr_q, SW'(push_eff));
        cnt_d = cnt_q + CNT_W'(push_eff) - CNT_W'(pop_eff);
        if (flush_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end
    end

    // Per-lane write enables; entries popped straight through are skipped
    always_comb begin
        for (int k = 0; k < NR_PORTS; k++) begin
            widx[k] = wrap_add(wr_q, SW'(k));
            ridx[k] = wrap_add(rd_q, SW'(k));
            we[k]   = !flush_i && (PCNT_W'(k) < push_eff);
            if (FALL_THROUGH && (SW'(cnt_q) + SW'(k) < SW'(pop_eff)))
                we[k] = 1'b0;
        end
    end

    // Head lanes: stored entries first, then bypassed push lanes
    always_comb begin
        for (int k = 0; k < NR_PORTS; k++) begin
            data_o[k] = '0;
            for (int i = 0; i < DEPTH; i++)
                if (ridx[k] == CNT_W'(i)) data_o[k] = mem_q[i];
            if (FALL_THROUGH && (k >= int'(cnt_q)))
                for (int j = 0; j < NR_PORTS; j++)
                    if (j == k - int'(cnt_q)) data_o[k] = data_i[j];
        end
    end

    // Pointer and count state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage, written only by enabled push lanes
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                for (int k = 0; k < NR_PORTS; k++)
                    if (we[k] && (widx[k] == CNT_W'(i)))
                        mem_q[i] <= data_i[k];
        end
    end

    assign avail_o       = avail;
    assign free_o        = free;
    assign usage_o       = cnt_q;
    assign full_o        = (cnt_q == CNT_W'(DEPTH));
    assign almost_full_o = (int'(cnt_q) >= AFULL_THRESH);
    assign empty_o       = (avail == '0);

`ifdef CVA6_MPFIFO_CHECK_EN
    logic err_q;

    // Sticky error on any clamped request, cleared by flush
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) err_q <= 1'b0;
        else if (flush_i) err_q <= 1'b0;
        else if (clamp) err_q <= 1'b1;
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;

`ifndef SYNTHESIS
    // Illegal request counts are fatal when no clamp logic exists
    always @(posedge clk_i) begin
        if (rst_ni && !flush_i) begin
            assert (CNT_W'(push_cnt_i) <= free_o)
            else $fatal(1, "push_cnt_i exceeds free_o");
            assert (pop_cnt_i <= avail_o)
            else $fatal(1, "pop_cnt_i exceeds avail_o");
        end
    end
`endif
`endif

endmodule
